// File: rtl/peak_interval_monitor.sv
// peak_interval_monitor
//   Watches the single-bit peak indicator from the upstream volume controller.
//   It counts rising edges, measures the number of clk edges between
//   successive accepted rises, and pushes each interval into a 2-entry FIFO
//   that a consumer drains. A sticky watchdog flag is raised when no rise
//   arrives within TIMEOUT cycles of the last accepted one.
//
// Optional build macro: PEAK_DEBOUNCE_EN
//   When defined, a rise seen in MEASURE whose interval would be below MIN_GAP
//   is ignored: no push, no peak_count change, and the interval keeps counting.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   sig_in        peak indicator (high while volume equals the limit)
//   clr           synchronous soft clear; same as rst except sig_q keeps sampling
//   out_valid     FIFO head holds a valid interval
//   out_ready     consumer accepts the head this cycle
//   out_interval  interval at the FIFO head, 0 when the FIFO is empty
//   peak_count    accepted rising edges, saturating at 16'hFFFF
//   timeout_flag  sticky watchdog alarm
//   overflow      sticky: an interval was dropped because the FIFO was full
//   armed         high while the FSM is in MEASURE (state observation point)
//
// Handshake: a transfer happens on every rising clk edge where out_valid and
// out_ready are both high. out_valid/out_interval depend only on registered
// state, never combinationally on out_ready. A push into an empty FIFO becomes
// visible on the following cycle.
module peak_interval_monitor #(
  parameter int CBITS   = 16,
  parameter int TIMEOUT = 40000,
  parameter int MIN_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CBITS-1:0] out_interval,
  output logic [15:0]      peak_count,
  output logic             timeout_flag,
  output logic             overflow,
  output logic             armed
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [CBITS-1:0] CNT_MAX = '1;
  // The watchdog fires when cnt+1 would reach TIMEOUT, i.e. cnt == TIMEOUT-1.
  localparam logic [CBITS-1:0] TO_LAST = CBITS'(TIMEOUT - 1);

  state_t           state;
  logic             sig_q;
  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] q0;   // head entry; kept at 0 while the FIFO is empty
  logic [CBITS-1:0] q1;   // second entry; kept at 0 unless the FIFO is full
  logic [1:0]       q_cnt;

  logic             rise;
  logic             accept;
  logic             gap_ok;
  logic [CBITS-1:0] cnt_p1;
  logic             push;
  logic             pop;
  logic             push_ok;

  // Saturating cnt+1; this is both the next count and the pushed interval.
  assign cnt_p1 = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign rise   = sig_in & ~sig_q;

`ifdef PEAK_DEBOUNCE_EN
  assign gap_ok = ({1'b0, cnt} + 1'b1) >= (CBITS + 1)'(MIN_GAP);
`else
  // MIN_GAP only matters in the debounced build.
  logic unused_min_gap;
  assign unused_min_gap = (MIN_GAP != 0);
  assign gap_ok = 1'b1;
`endif

  // Rises in IDLE always start a measurement; debounce applies only in MEASURE.
  assign accept  = rise & ((state == IDLE) | gap_ok);
  assign push    = (state == MEASURE) & accept;
  assign pop     = out_valid & out_ready;
  assign push_ok = push & ((q_cnt != 2'd2) | pop);

  assign out_valid    = (q_cnt != 2'd0);
  assign out_interval = q0;
  assign armed        = (state == MEASURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q        <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      peak_count   <= '0;
      timeout_flag <= 1'b0;
      overflow     <= 1'b0;
      q0           <= '0;
      q1           <= '0;
      q_cnt        <= 2'd0;
    end else begin
      sig_q <= sig_in;
      if (clr) begin
        state        <= IDLE;
        cnt          <= '0;
        peak_count   <= '0;
        timeout_flag <= 1'b0;
        overflow     <= 1'b0;
        q0           <= '0;
        q1           <= '0;
        q_cnt        <= 2'd0;
      end else begin
        // FSM and interval counter
        case (state)
          IDLE: begin
            cnt <= '0;
            if (accept) begin
              state <= MEASURE;
              if (peak_count != 16'hFFFF) peak_count <= peak_count + 16'd1;
            end
          end
          MEASURE: begin
            if (accept) begin
              cnt <= '0;
              if (peak_count != 16'hFFFF) peak_count <= peak_count + 16'd1;
            end else if (cnt == TO_LAST) begin
              timeout_flag <= 1'b1;
              state        <= IDLE;
              cnt          <= '0;
            end else begin
              cnt <= cnt_p1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase

        // Two-entry FIFO held as a shift pair: q0 is always the head.
        if (push & ~push_ok) overflow <= 1'b1;
        if (pop & push_ok) begin
          if (q_cnt == 2'd1) begin
            q0 <= cnt_p1;
          end else begin
            q0 <= q1;
            q1 <= cnt_p1;
          end
        end else if (pop) begin
          q0    <= q1;
          q1    <= '0;
          q_cnt <= q_cnt - 2'd1;
        end else if (push_ok) begin
          if (q_cnt == 2'd0) q0 <= cnt_p1;
          else               q1 <= cnt_p1;
          q_cnt <= q_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_interval_monitor.sv
module tb_peak_interval_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_interval;
  logic [15:0] peak_count;
  logic        timeout_flag;
  logic        overflow;
  logic        armed;

  int tests_run = 0;
  int tests_failed = 0;

  // Clock / reset
  always #5 clk = ~clk;

  peak_interval_monitor #(.CBITS(16), .TIMEOUT(40000), .MIN_GAP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .clr          (clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_interval (out_interval),
    .peak_count   (peak_count),
    .timeout_flag (timeout_flag),
    .overflow     (overflow),
    .armed        (armed)
  );

  // Driver tasks: inputs change 1 time unit after the edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Next rise exactly n clk edges after the previous rise (n >= 2).
  task automatic gap(input int n);
    sig_in = 1'b0;
    ticks(n - 1);
    sig_in = 1'b1;
    tick();
  endtask

  task automatic do_clr();
    sig_in = 1'b0;
    clr    = 1'b1;
    tick();
    clr    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"},   32'(out_valid),    32'd0);
    chk({tag, "_intv"},    32'(out_interval), 32'd0);
    chk({tag, "_peaks"},   32'(peak_count),   32'd0);
    chk({tag, "_timeout"}, 32'(timeout_flag), 32'd0);
    chk({tag, "_ovf"},     32'(overflow),     32'd0);
    chk({tag, "_armed"},   32'(armed),        32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; sig_in = 1'b0; out_ready = 1'b0;
    ticks(2);
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Interval of 25 cycles, consumer always ready
    out_ready = 1'b1;
    sig_in = 1'b1;
    tick();
    chk("t1_armed", 32'(armed), 32'd1);
    chk("t1_peak1", 32'(peak_count), 32'd1);
    chk("t1_nopush", 32'(out_valid), 32'd0);
    gap(25);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_intv", 32'(out_interval), 32'd25);
    chk("t1_peak2", 32'(peak_count), 32'd2);
    sig_in = 1'b0;
    tick();
    chk("t1_valid_1cyc", 32'(out_valid), 32'd0);
    chk("t1_intv_zero", 32'(out_interval), 32'd0);

    // Held high counts as one rise
    do_clr();
    chk_idle_outputs("clr1");
    sig_in = 1'b1;
    ticks(51);
    chk("t2_peaks", 32'(peak_count), 32'd1);
    chk("t2_nopush", 32'(out_valid), 32'd0);
    chk("t2_armed", 32'(armed), 32'd1);

    // Watchdog: flag exactly TIMEOUT cycles after the rise
    do_clr();
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
    ticks(39999);
    chk("t3_no_to_yet", 32'(timeout_flag), 32'd0);
    chk("t3_armed_yet", 32'(armed), 32'd1);
    tick();
    chk("t3_timeout", 32'(timeout_flag), 32'd1);
    chk("t3_disarmed", 32'(armed), 32'd0);
    sig_in = 1'b1;
    tick();
    chk("t3_rearmed", 32'(armed), 32'd1);
    chk("t3_peaks", 32'(peak_count), 32'd2);
    chk("t3_nopush", 32'(out_valid), 32'd0);
    chk("t3_sticky", 32'(timeout_flag), 32'd1);

    // Overflow: intervals 100, 200, 300 with consumer stalled
    do_clr();
    out_ready = 1'b0;
    sig_in = 1'b1;
    tick();
    gap(100);
    gap(200);
    chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
    gap(300);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_head", 32'(out_interval), 32'd100);
    chk("t4_peaks", 32'(peak_count), 32'd4);
    sig_in = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4_pop1", 32'(out_interval), 32'd200);
    chk("t4_pop1_valid", 32'(out_valid), 32'd1);
    tick();
    chk("t4_empty", 32'(out_valid), 32'd0);
    chk("t4_empty_intv", 32'(out_interval), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);

    // Push into a full queue in the same cycle as a pop
    do_clr();
    out_ready = 1'b0;
    sig_in = 1'b1;
    tick();
    gap(100);
    gap(200);
    sig_in = 1'b0;
    ticks(49);
    sig_in = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t5_no_ovf", 32'(overflow), 32'd0);
    chk("t5_head", 32'(out_interval), 32'd200);
    sig_in = 1'b0;
    tick();
    chk("t5_head2", 32'(out_interval), 32'd50);
    chk("t5_valid2", 32'(out_valid), 32'd1);
    tick();
    chk("t5_empty", 32'(out_valid), 32'd0);

    // Intervals 2 then 10
    do_clr();
    out_ready = 1'b0;
    sig_in = 1'b1;
    tick();
    gap(2);
    gap(10);
`ifdef PEAK_DEBOUNCE_EN
    chk("t6_head", 32'(out_interval), 32'd12);
    chk("t6_peaks", 32'(peak_count), 32'd2);
    sig_in = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t6_single", 32'(out_valid), 32'd0);
`else
    chk("t6_head", 32'(out_interval), 32'd2);
    chk("t6_peaks", 32'(peak_count), 32'd3);
    sig_in = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t6_second", 32'(out_interval), 32'd10);
`endif
    chk("t6_armed", 32'(armed), 32'd1);

    // clr mid-measure
    out_ready = 1'b0;
    gap(30);
    chk("t7_pre_valid", 32'(out_valid), 32'd1);
    do_clr();
    chk_idle_outputs("clr_mid");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
